defunnel_stream: RTL and testbench

- Parametrised, handshaked successor to the fixed-ratio data defunnel.
- Gathers narrow beats of 1, 2, 4 … IN_LANES chunks from a target-side stream into one wide CHUNKS-chunk word. Emits that word on an initiator-side valid/ready port.
- Adds backpressure, per-word mode latching, early termination via t_last, and a chunk-keep mask.
- Sits between the radix datapath narrow lanes and wide-bus consumers (DMA/packer).

---
 rtl/defunnel_stream.sv | 113 +++++++++++
 tb/tb_defunnel_stream.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/defunnel_stream.sv
// rtl/defunnel_stream.sv - Gathers narrow handshaked beats into wide chunk words with keep mask.
module defunnel_stream #(
    parameter int CHUNK_W  = 32,
    parameter int IN_LANES = 4,
    parameter int CHUNKS   = 8,
    parameter int MODE_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [IN_LANES*CHUNK_W-1:0] t_dat,
    input  logic                        t_valid,
    input  logic                        t_last,
    output logic                        t_ready,
    input  logic [MODE_W-1:0]           t_cfg_dat,
    output logic [CHUNKS*CHUNK_W-1:0]   i_dat,
    output logic [CHUNKS-1:0]           i_keep,
    output logic                        i_valid,
    input  logic                        i_ready,
    output logic                        cfg_err
);
    localparam int LOG_IN    = $clog2(IN_LANES);
    localparam int MODE_BITS = LOG_IN + 1;
    localparam int PTR_W     = $clog2(CHUNKS) + 1;

    localparam logic [MODE_BITS-1:0] MAX_MODE  = MODE_BITS'(LOG_IN);
    localparam logic [PTR_W-1:0]     FULL_PTR  = PTR_W'(CHUNKS);
    localparam logic [PTR_W-1:0]     MAX_LANES = PTR_W'(IN_LANES);

    logic [PTR_W-1:0]          ptrQ;
    logic [PTR_W-1:0]          lanesQ;
    logic [PTR_W-1:0]          cfgLanes;
    logic [PTR_W-1:0]          effLanes;
    logic [PTR_W-1:0]          ptrSum;
    logic [MODE_BITS-1:0]      mode;
    logic                      modeIllegal;
    logic                      wordStart;
    logic                      closing;
    logic                      accept;
    logic                      drain;
    logic [CHUNKS*CHUNK_W-1:0] asmQ;
    logic [CHUNKS*CHUNK_W-1:0] asmNext;
    logic [CHUNKS-1:0]         keepQ;
    logic [CHUNKS-1:0]         keepNext;
    logic                      unusedCfg;

    // Only the low mode bits matter; upper configuration bits are reserved.
    assign unusedCfg   = ^t_cfg_dat;
    assign mode        = t_cfg_dat[MODE_BITS-1:0];
    assign modeIllegal = (mode > MAX_MODE);
    assign cfgLanes    = modeIllegal ? MAX_LANES : (PTR_W'(1) << mode);

    // At a word start the lane count comes straight from the live mode input.
    assign wordStart = (ptrQ == '0);
    assign effLanes  = wordStart ? cfgLanes : lanesQ;
    assign ptrSum    = ptrQ + effLanes;
    assign closing   = (ptrSum == FULL_PTR) || t_last;

    // Only a closing beat needs room in the output register.
    assign t_ready = !closing || !i_valid || i_ready;
    assign accept  = t_valid && t_ready;
    assign drain   = i_valid && i_ready;

    always_comb begin
        asmNext  = asmQ;
        keepNext = keepQ;
        for (int j = 0; j < CHUNKS; j++) begin
            for (int k = 0; k < IN_LANES; k++) begin
                if ((k < int'(effLanes)) && (j == int'(ptrQ) + k)) begin
                    asmNext[j*CHUNK_W +: CHUNK_W] = t_dat[k*CHUNK_W +: CHUNK_W];
                    keepNext[j]                   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptrQ    <= '0;
            lanesQ  <= PTR_W'(1);
            asmQ    <= '0;
            keepQ   <= '0;
            i_dat   <= '0;
            i_keep  <= '0;
            i_valid <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            if (accept && wordStart) begin
                lanesQ <= cfgLanes;
                if (modeIllegal) begin
                    cfg_err <= 1'b1;
                end
            end
            if (accept && closing) begin
                // A close while draining reloads the output, keeping i_valid high.
                i_dat   <= asmNext;
                i_keep  <= keepNext;
                i_valid <= 1'b1;
                asmQ    <= '0;
                keepQ   <= '0;
                ptrQ    <= '0;
            end else begin
                if (accept) begin
                    asmQ  <= asmNext;
                    keepQ <= keepNext;
                    ptrQ  <= ptrSum;
                end
                if (drain) begin
                    i_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_defunnel_stream.sv
// tb/tb_defunnel_stream.sv - Randomized and directed bench for defunnel_stream against a queue model.
module tb_defunnel_stream;
    localparam int CHUNK_W  = 32;
    localparam int IN_LANES = 4;
    localparam int CHUNKS   = 8;
    localparam int MODE_W   = 8;
    localparam int LOG_IN   = $clog2(IN_LANES);
    localparam int IW       = IN_LANES * CHUNK_W;
    localparam int OW       = CHUNKS * CHUNK_W;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b1;
    logic [IW-1:0]     t_dat     = '0;
    logic              t_valid   = 1'b0;
    logic              t_last    = 1'b0;
    logic              t_ready;
    logic [MODE_W-1:0] t_cfg_dat = '0;
    logic [OW-1:0]     i_dat;
    logic [CHUNKS-1:0] i_keep;
    logic              i_valid;
    logic              i_ready   = 1'b0;
    logic              cfg_err;

    always #5 clk = ~clk;

    defunnel_stream #(
        .CHUNK_W (CHUNK_W),
        .IN_LANES(IN_LANES),
        .CHUNKS  (CHUNKS),
        .MODE_W  (MODE_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .t_dat    (t_dat),
        .t_valid  (t_valid),
        .t_last   (t_last),
        .t_ready  (t_ready),
        .t_cfg_dat(t_cfg_dat),
        .i_dat    (i_dat),
        .i_keep   (i_keep),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .cfg_err  (cfg_err)
    );

    int checks = 0;
    int passed = 0;

    task automatic checkVal(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Reference model: the word in progress is a plain queue of chunks.
    logic [CHUNK_W-1:0] cur[$];
    int                 curL     = 1;
    bit                 outFull  = 1'b0;
    bit                 errModel = 1'b0;
    logic [OW-1:0]      outDat   = '0;
    logic [CHUNKS-1:0]  outKeep  = '0;

    function automatic logic [IW-1:0] mkBeat(input int v);
        logic [IW-1:0] b;
        for (int k = 0; k < IN_LANES; k++) b[k*CHUNK_W +: CHUNK_W] = CHUNK_W'(v + (k << 12));
        return b;
    endfunction

    task automatic cycle(input bit tv, input bit tl, input logic [MODE_W-1:0] cfg,
                         input logic [IW-1:0] dat, input bit ir, output bit accepted);
        int m;
        int lanes;
        int sz;
        bit closing;
        bit expReady;
        t_valid = tv; t_last = tl; t_cfg_dat = cfg; t_dat = dat; i_ready = ir;
        #1;
        sz       = cur.size();
        m        = int'(cfg) % (2 * IN_LANES);
        lanes    = (sz == 0) ? ((m > LOG_IN) ? IN_LANES : (1 << m)) : curL;
        closing  = ((sz + lanes) == CHUNKS) || tl;
        expReady = !closing || !outFull || ir;
        checkVal("t_ready", OW'(t_ready), OW'(expReady));
        checkVal("i_valid", OW'(i_valid), OW'(outFull));
        checkVal("cfg_err", OW'(cfg_err), OW'(errModel));
        if (outFull) begin
            checkVal("i_dat", i_dat, outDat);
            checkVal("i_keep", OW'(i_keep), OW'(outKeep));
        end
        accepted = tv && expReady;
        if (outFull && ir) outFull = 1'b0;
        if (accepted) begin
            if (sz == 0) begin
                curL = lanes;
                if (m > LOG_IN) errModel = 1'b1;
            end
            for (int k = 0; k < lanes; k++) cur.push_back(dat[k*CHUNK_W +: CHUNK_W]);
            if (closing) begin
                outDat = '0;
                foreach (cur[i]) outDat[i*CHUNK_W +: CHUNK_W] = cur[i];
                outKeep = CHUNKS'((1 << cur.size()) - 1);
                outFull = 1'b1;
                cur.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) cycle(1'b0, 1'b0, '0, '0, 1'b1, a);
    endtask

    task automatic stream(input int nBeats, input int modeA, input int modeB, input int switchAt,
                          input int lastAt, input int stall, input int base);
        int n = 0;
        int cyc = 0;
        bit a;
        while (n < nBeats && cyc < 1000) begin
            cycle(1'b1, n == lastAt, MODE_W'((n >= switchAt) ? modeB : modeA),
                  mkBeat(base + n), cyc >= stall, a);
            if (a) n++;
            cyc++;
        end
        if (n < nBeats) checkVal("stream_timeout", OW'(n), OW'(nBeats));
    endtask

    task automatic doReset();
        reset_n = 1'b0; t_valid = 1'b0; t_last = 1'b0; i_ready = 1'b0;
        #1;
        checkVal("rst_i_valid", OW'(i_valid), '0);
        checkVal("rst_i_keep", OW'(i_keep), '0);
        checkVal("rst_i_dat", i_dat, '0);
        checkVal("rst_cfg_err", OW'(cfg_err), '0);
        cur.delete(); curL = 1; outFull = 1'b0; errModel = 1'b0; outDat = '0; outKeep = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        @(negedge clk);
        doReset();

        stream(8, 0, 0, 8, -1, 0, 32'h100);
        checkVal("tp1_valid", OW'(i_valid), OW'(1));
        checkVal("tp1_keep", OW'(i_keep), OW'(8'hFF));
        checkVal("tp1_chunk5", OW'(i_dat[5*CHUNK_W +: CHUNK_W]), OW'(32'h105));
        idle(3);

        stream(12, 2, 2, 12, -1, 0, 32'h200);
        idle(3);

        stream(12, 1, 1, 12, -1, 14, 32'h300);
        idle(3);

        stream(2, 1, 1, 2, 1, 0, 32'h400);
        checkVal("tp4_keep", OW'(i_keep), OW'(8'h0F));
        checkVal("tp4_upper_zero", OW'(i_dat[OW-1:OW/2]), '0);
        stream(4, 1, 1, 4, -1, 0, 32'h480);
        idle(3);

        stream(12, 0, 2, 3, -1, 0, 32'h500);
        idle(3);

        stream(2, 5, 5, 2, -1, 0, 32'h600);
        checkVal("tp6_cfg_err", OW'(cfg_err), OW'(1));
        checkVal("tp6_keep", OW'(i_keep), OW'(8'hFF));
        idle(2);
        stream(4, 0, 0, 4, -1, 0, 32'h700);
        doReset();
        stream(8, 0, 0, 8, -1, 0, 32'h800);
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  MODE_W'(($urandom & 32'hF8) | $urandom_range(0, LOG_IN)),
                  {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2) != 0, a);
        end
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, MODE_W'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2) != 0, a);
        end
        idle(4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
